seg_to_bcd_rx: RTL

Receive-side decoder for the two-digit 7-segment bus the clock counters drive. It samples a pair of segment patterns (`seg_data1` for units, `seg_data2` for tens) and waits until the pair has held steady for a set number of samples. It then decodes each pattern back to BCD and presents the result on a valid/ready handshake. It sits downstream of the counter/display path as a self-check monitor, or upstream of logic that needs the displayed value in numeric form.

---
 rtl/seg_to_bcd_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seg_to_bcd_rx.sv
// Two-digit 7-segment receive decoder: settles, decodes to BCD, valid/ready out.
// Optional saturating error counter on err_cnt under SEG_RX_ERRCNT_EN.
module seg_to_bcd_rx #(
    parameter int STABLE_N = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [7:0] seg_data1,
    input  logic [7:0] seg_data2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic       blank1,
    output logic       blank2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic       err
`ifdef SEG_RX_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    // Result is {legal, blank, bcd}; input has dp already cleared.
    function automatic logic [5:0] dec(input logic [7:0] s);
        case (s)
            8'hFC:   dec = 6'b10_0000;
            8'h60:   dec = 6'b10_0001;
            8'hDA:   dec = 6'b10_0010;
            8'hF2:   dec = 6'b10_0011;
            8'h66:   dec = 6'b10_0100;
            8'hB6:   dec = 6'b10_0101;
            8'hBE:   dec = 6'b10_0110;
            8'hE0:   dec = 6'b10_0111;
            8'hFE:   dec = 6'b10_1000;
            8'hF6:   dec = 6'b10_1001;
            8'h00:   dec = 6'b11_1111;
            default: dec = 6'b00_1111;
        endcase
    endfunction

    logic [1:0]  state;
    logic [13:0] cand;
    logic [13:0] last;
    logic [7:0]  stab_cnt;
    logic        first;

    logic [7:0]  m1;
    logic [7:0]  m2;
    logic [13:0] pair;
    logic [5:0]  d1;
    logic [5:0]  d2;
    logic        same;
    logic        at_n;
    logic        try_pub;
    logic        legal;
    logic        pub;
    logic        bad;
    logic        accept;

    always_comb begin
        m1      = seg_data1 & 8'hFE;
        m2      = seg_data2 & 8'hFE;
        pair    = {m2[7:1], m1[7:1]};
        d1      = dec(m1);
        d2      = dec(m2);
        same    = (pair == cand);
        at_n    = (stab_cnt == 8'(STABLE_N - 1));
        try_pub = sample_en && (state == SETTLE) && same && at_n;
        legal   = d1[5] && d2[5];
        pub     = try_pub && legal && (first || (pair != last));
        bad     = try_pub && !legal;
        accept  = out_valid && out_ready;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            last      <= '0;
            stab_cnt  <= '0;
            first     <= 1'b1;
            bcd1      <= '0;
            bcd2      <= '0;
            blank1    <= 1'b0;
            blank2    <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            err       <= 1'b0;
        end else begin
            overrun <= pub && out_valid && !out_ready;
            err     <= bad;
            if (pub) begin
                bcd1      <= d1[3:0];
                bcd2      <= d2[3:0];
                blank1    <= d1[4];
                blank2    <= d2[4];
                out_valid <= 1'b1;
                last      <= pair;
                first     <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (sample_en) begin
                case (state)
                    IDLE: begin
                        cand     <= pair;
                        stab_cnt <= 8'd1;
                        state    <= SETTLE;
                    end
                    SETTLE: begin
                        if (!same) begin
                            cand     <= pair;
                            stab_cnt <= 8'd1;
                        end else if (at_n) begin
                            state <= HOLD;
                        end else begin
                            stab_cnt <= stab_cnt + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (!same) begin
                            cand     <= pair;
                            stab_cnt <= 8'd1;
                            state    <= SETTLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SEG_RX_ERRCNT_EN
    always_ff @(posedge clk_in) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
